// File: rtl/tt_sweep_pkg.sv
// Shared types and default constants for the truth-table sweeper.
// The sweep state is also exported as a debug output so checkers can observe it.
package tt_sweep_pkg;

  localparam int N_IN_DEFAULT = 4;
  localparam int NUM_VEC      = 2 ** N_IN_DEFAULT;
  localparam int CNT_W        = $clog2(NUM_VEC + 1);

  localparam logic [NUM_VEC-1:0] DEFAULT_TABLE = 16'hAAEA;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down-counter. tick is high for the enabled cycle in which the count is zero.
// A load has priority over counting, so a reload on tick starts the next hold period at once.
module settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_value,
  output logic         tick
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tick = en && (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input combination into a combinational block, captures its output
// into a truth table, counts the ones and compares against an expected table.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int                       N_IN           = 4,
  parameter int                       SETTLE_CYCLES  = 2,
  parameter logic [(2**N_IN)-1:0]     EXPECTED_TABLE = DEFAULT_TABLE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic [N_IN-1:0]                 vec,
  input  logic                            r_in,
  output logic                            busy,
  output logic                            done,
  output logic [(2**N_IN)-1:0]            table_out,
  output logic [$clog2(2**N_IN+1)-1:0]    ones_count,
  output logic                            pass,
  output logic [1:0]                      dbg_state
);

  localparam int NV    = 2 ** N_IN;
  localparam int OW    = $clog2(NV + 1);
  localparam int IDX_W = N_IN + 1;

  // Valid/ready contract: start is a level request sampled only in IDLE;
  // done is a single-cycle result strobe with no back-pressure.

  state_t           state, state_next;
  logic [IDX_W-1:0] index;
  logic [NV-1:0]    cap_table;
  logic             accept, sample, last;

  assign accept = (state == IDLE) && start;
  assign last   = (index == IDX_W'(NV - 1));

  settle_timer #(.W(8)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (accept || sample),
    .en         (state == SETTLE),
    .load_value (8'(SETTLE_CYCLES - 1)),
    .tick       (sample)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETTLE;
      SETTLE:  if (sample && last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Table as it will look once the current sample lands; also feeds the final compare.
  always_comb begin
    cap_table = table_out;
    cap_table[index[N_IN-1:0]] = r_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index      <= '0;
      table_out  <= '0;
      ones_count <= '0;
      pass       <= 1'b0;
    end else if (accept) begin
      index      <= '0;
      table_out  <= '0;
      ones_count <= '0;
      pass       <= 1'b0;
    end else if (sample) begin
      table_out  <= cap_table;
      ones_count <= ones_count + OW'(r_in);
      if (last) begin
        index <= '0;
        pass  <= (cap_table == EXPECTED_TABLE);
      end else begin
        index <= index + 1'b1;
      end
    end
  end

  // vec comes straight from a register, so it changes cleanly once per hold period.
  assign vec       = index[N_IN-1:0];
  assign busy      = (state == SETTLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: three instances with settle times 1, 2 and 3,
// the 2-cycle one additionally switchable to a constant-0 or constant-1 block output.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst;
  logic start;
  int   mode;

  always #5 clk = ~clk;

  logic [3:0]  vec1, vec2, vec3;
  logic        r1, r2, r3;
  logic        busy1, busy2, busy3;
  logic        done1, done2, done3;
  logic [15:0] tab1, tab2, tab3;
  logic [4:0]  ones1, ones2, ones3;
  logic        pass1, pass2, pass3;
  logic [1:0]  st1, st2, st3;

  function automatic logic gate(input logic [3:0] v);
    return (~v[3] & v[2] & v[1]) | v[0];
  endfunction

  assign r1 = gate(vec1);
  assign r3 = gate(vec3);
  assign r2 = (mode == 0) ? gate(vec2) : (mode == 1) ? 1'b0 : 1'b1;

  truth_table_sweeper #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .vec(vec1), .r_in(r1), .busy(busy1),
    .done(done1), .table_out(tab1), .ones_count(ones1), .pass(pass1), .dbg_state(st1));
  truth_table_sweeper #(.SETTLE_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .vec(vec2), .r_in(r2), .busy(busy2),
    .done(done2), .table_out(tab2), .ones_count(ones2), .pass(pass2), .dbg_state(st2));
  truth_table_sweeper #(.SETTLE_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .start(start), .vec(vec3), .r_in(r3), .busy(busy3),
    .done(done3), .table_out(tab3), .ones_count(ones3), .pass(pass3), .dbg_state(st3));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Returns the number of edges until done2 rises, or budget if it never does.
  task automatic wait_done(input int budget, output int k);
    k = 0;
    while (k < budget) begin
      step();
      k++;
      if (done2) break;
    end
  endtask

  task automatic chk_timing(input int s, input int k, input logic [3:0] v,
                            input logic b, input logic d);
    int end_k;
    end_k = 16 * s;
    chk($sformatf("s%0d_k%0d_vec", s, k), 32'(v), (k < end_k) ? 32'(k / s) : 32'd0);
    chk($sformatf("s%0d_k%0d_busy", s, k), 32'(b), (k < end_k) ? 32'd1 : 32'd0);
    chk($sformatf("s%0d_k%0d_done", s, k), 32'(d), (k == end_k) ? 32'd1 : 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int ndone;
    int done_k;
    bit busy_seen;

    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    #12;
    chk("rst_vec",   32'(vec2),  32'd0);
    chk("rst_busy",  32'(busy2), 32'd0);
    chk("rst_done",  32'(done2), 32'd0);
    chk("rst_table", 32'(tab2),  32'd0);
    chk("rst_ones",  32'(ones2), 32'd0);
    chk("rst_pass",  32'(pass2), 32'd0);
    chk("rst_state", 32'(st2),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Gate block on all three instances; track vec/busy/done every cycle.
    pulse_start();
    chk("acc_busy", 32'(busy2), 32'd1);
    chk("acc_vec",  32'(vec2),  32'd0);
    for (int kk = 1; kk <= 48; kk++) begin
      step();
      chk_timing(1, kk, vec1, busy1, done1);
      chk_timing(2, kk, vec2, busy2, done2);
      chk_timing(3, kk, vec3, busy3, done3);
    end
    chk("s1_table", 32'(tab1), 32'h0000AAEA);
    chk("s1_ones",  32'(ones1), 32'd9);
    chk("s1_pass",  32'(pass1), 32'd1);
    chk("s2_table", 32'(tab2), 32'h0000AAEA);
    chk("s2_ones",  32'(ones2), 32'd9);
    chk("s2_pass",  32'(pass2), 32'd1);
    chk("s3_table", 32'(tab3), 32'h0000AAEA);
    chk("s3_ones",  32'(ones3), 32'd9);
    chk("s3_pass",  32'(pass3), 32'd1);

    // Constant-0 block output.
    mode = 1;
    step();
    pulse_start();
    wait_done(40, k);
    chk("zero_latency", 32'(k), 32'd32);
    chk("zero_table", 32'(tab2), 32'h0);
    chk("zero_ones",  32'(ones2), 32'd0);
    chk("zero_pass",  32'(pass2), 32'd0);

    // Constant-1 block output.
    mode = 2;
    step();
    pulse_start();
    wait_done(40, k);
    chk("one_latency", 32'(k), 32'd32);
    chk("one_table", 32'(tab2), 32'h0000FFFF);
    chk("one_ones",  32'(ones2), 32'd16);
    chk("one_pass",  32'(pass2), 32'd0);
    mode = 0;
    repeat (20) step();

    // Asynchronous reset in the middle of a sweep.
    pulse_start();
    repeat (10) step();
    chk("mid_vec",   32'(vec2),  32'd5);
    chk("mid_table", 32'(tab2),  32'h0000000A);
    chk("mid_ones",  32'(ones2), 32'd2);
    #3 rst = 1'b1;
    #1;
    chk("arst_vec",   32'(vec2),  32'd0);
    chk("arst_busy",  32'(busy2), 32'd0);
    chk("arst_done",  32'(done2), 32'd0);
    chk("arst_table", 32'(tab2),  32'd0);
    chk("arst_ones",  32'(ones2), 32'd0);
    chk("arst_pass",  32'(pass2), 32'd0);
    chk("arst_state", 32'(st2),   32'd0);
    #2 rst = 1'b0;
    ndone = 0;
    busy_seen = 1'b0;
    for (int kk = 0; kk < 40; kk++) begin
      step();
      if (done2) ndone++;
      if (busy2) busy_seen = 1'b1;
    end
    chk("arst_no_done", 32'(ndone), 32'd0);
    chk("arst_no_busy", 32'(busy_seen), 32'd0);
    pulse_start();
    wait_done(40, k);
    chk("post_rst_latency", 32'(k), 32'd32);
    chk("post_rst_table", 32'(tab2), 32'h0000AAEA);
    chk("post_rst_ones",  32'(ones2), 32'd9);
    chk("post_rst_pass",  32'(pass2), 32'd1);

    // start re-pulsed during SETTLE must be ignored.
    step();
    pulse_start();
    ndone  = 0;
    done_k = 0;
    for (int kk = 1; kk <= 40; kk++) begin
      start = (kk == 8);
      step();
      if (done2) begin
        ndone++;
        done_k = kk;
      end
    end
    start = 1'b0;
    chk("retrig_ndone",  32'(ndone),  32'd1);
    chk("retrig_done_k", 32'(done_k), 32'd32);
    chk("retrig_table",  32'(tab2),   32'h0000AAEA);

    // start held high: back-to-back sweeps with one IDLE cycle after DONE.
    chk("held_pre_table", 32'(tab2), 32'h0000AAEA);
    start = 1'b1;
    step();
    chk("held_acc_busy",  32'(busy2), 32'd1);
    chk("held_acc_table", 32'(tab2),  32'd0);
    repeat (32) step();
    chk("held_done",  32'(done2), 32'd1);
    chk("held_table", 32'(tab2),  32'h0000AAEA);
    step();
    chk("held_idle_done",  32'(done2), 32'd0);
    chk("held_idle_busy",  32'(busy2), 32'd0);
    chk("held_idle_table", 32'(tab2),  32'h0000AAEA);
    step();
    chk("held_reacc_busy",  32'(busy2), 32'd1);
    chk("held_reacc_table", 32'(tab2),  32'd0);
    chk("held_reacc_vec",   32'(vec2),  32'd0);
    wait_done(40, k);
    start = 1'b0;
    chk("held2_latency", 32'(k), 32'd32);
    chk("held2_table", 32'(tab2), 32'h0000AAEA);
    chk("held2_ones",  32'(ones2), 32'd9);
    chk("held2_pass",  32'(pass2), 32'd1);
    step();
    step();
    chk("final_state", 32'(st2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
